// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: shared parity modes, serializer state encoding and baud default
package uart_tx_fifo_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD = 1;
  localparam int PARITY_EVEN = 2;
  localparam int CLKS_115200 = 434;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
endpackage

// File: rtl/uart_tx_fifo_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic we, re;
  assign we = wr && !full;
  assign re = rd && !empty;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (we) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(we);
      rp <= rp + AW'(re);
      count <= count + CW'(we) - CW'(re);
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with configurable frame format
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_115200,
  parameter int FIFO_DEPTH = 64,
  parameter int DATA_BITS = 8,
  parameter int PARITY = PARITY_NONE,
  parameter int STOP_BITS = 1,
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       din,
  input  logic             writeEn,
  input  logic             txEnable,
  input  logic             clrOverflow,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             overflow,
  output logic             txData
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
  state_t state, nstate;
  logic [TW-1:0] tmr, ntmr;
  logic [DATA_BITS-1:0] sh, nsh, head;
  logic [2:0] bitn, nbit;
  logic par, npar, pop, last, start_ok;
  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk), .rst(rst), .wr(writeEn), .din(din[DATA_BITS-1:0]), .rd(pop),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  assign last = tmr == '0;
  assign start_ok = !empty && txEnable;
  assign busy = state != S_IDLE;
  assign txData = state == S_START ? 1'b0 : state == S_DATA ? sh[0] : state == S_PARITY ? par : 1'b1;
  always_comb begin
    nstate = state;
    ntmr = last ? TMAX : tmr - 1'b1;
    nsh = sh;
    nbit = bitn;
    npar = par;
    pop = 1'b0;
    case (state)
      S_IDLE: pop = start_ok;
      S_START: if (last) begin
        nstate = S_DATA;
        nbit = '0;
      end
      S_DATA: if (last) begin
        nsh = sh >> 1;
        nbit = bitn + 3'd1;
        if (bitn == 3'(DATA_BITS - 1)) begin
          nstate = PARITY != PARITY_NONE ? S_PARITY : S_STOP;
          nbit = '0;
        end
      end
      S_PARITY: if (last) nstate = S_STOP;
      S_STOP: if (last) begin
        nbit = bitn + 3'd1;
        if (bitn == 3'(STOP_BITS - 1)) begin
          nstate = S_IDLE;
          pop = start_ok;
        end
      end
      default: nstate = S_IDLE;
    endcase
    // a pop always launches a new frame, from IDLE or straight out of the last stop bit
    if (pop) begin
      nstate = S_START;
      ntmr = TMAX;
      nsh = head;
      npar = (^head) ^ (PARITY == PARITY_ODD);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      tmr <= TMAX;
      sh <= '0;
      bitn <= '0;
      par <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= nstate;
      tmr <= ntmr;
      sh <= nsh;
      bitn <= nbit;
      par <= npar;
      overflow <= (writeEn && full) || (overflow && !clrOverflow);
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed table-driven bench over four frame configurations
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [7:0] din [4];
  logic we [4], te [4], co [4];
  logic full [4], empty [4], busy [4], ovf [4], tx [4];
  logic [6:0] cnt [4];
  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(64), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .din(din[0]), .writeEn(we[0]), .txEnable(te[0]), .clrOverflow(co[0]),
    .full(full[0]), .empty(empty[0]), .count(cnt[0]), .busy(busy[0]), .overflow(ovf[0]), .txData(tx[0]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(64), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .din(din[1]), .writeEn(we[1]), .txEnable(te[1]), .clrOverflow(co[1]),
    .full(full[1]), .empty(empty[1]), .count(cnt[1]), .busy(busy[1]), .overflow(ovf[1]), .txData(tx[1]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(64), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .din(din[2]), .writeEn(we[2]), .txEnable(te[2]), .clrOverflow(co[2]),
    .full(full[2]), .empty(empty[2]), .count(cnt[2]), .busy(busy[2]), .overflow(ovf[2]), .txData(tx[2]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(64), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .din(din[3]), .writeEn(we[3]), .txEnable(te[3]), .clrOverflow(co[3]),
    .full(full[3]), .empty(empty[3]), .count(cnt[3]), .busy(busy[3]), .overflow(ovf[3]), .txData(tx[3]));

  typedef struct {
    int d;
    logic [7:0] data;
    logic [11:0] frame;
    int nbits;
  } vec_t;
  vec_t vt [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input int v);
    int d;
    d = vt[v].d;
    din[d] = vt[v].data;
    we[d] = 1'b1;
    @(negedge clk);
    we[d] = 1'b0;
    chk($sformatf("v%0d_empty_c1", v), 32'(empty[d]), 0);
    chk($sformatf("v%0d_count_c1", v), 32'(cnt[d]), 1);
    @(negedge clk);
    chk($sformatf("v%0d_count_c2", v), 32'(cnt[d]), 0);
    for (int k = 0; k < vt[v].nbits; k++)
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("v%0d_bit%0d_c%0d", v, k, c), 32'(tx[d]), 32'(vt[v].frame[k]));
        chk($sformatf("v%0d_busy%0d_c%0d", v, k, c), 32'(busy[d]), 1);
        @(negedge clk);
      end
    chk($sformatf("v%0d_busy_end", v), 32'(busy[d]), 0);
    chk($sformatf("v%0d_tx_end", v), 32'(tx[d]), 1);
    chk($sformatf("v%0d_empty_end", v), 32'(empty[d]), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] s;
    vt[0] = '{0, 8'h55, 12'h2AA, 10};
    vt[1] = '{1, 8'h03, 12'h406, 11};
    vt[2] = '{2, 8'h03, 12'h606, 11};
    vt[3] = '{2, 8'h00, 12'h600, 11};
    vt[4] = '{1, 8'h80, 12'h700, 11};
    vt[5] = '{3, 8'hFF, 12'h3FE, 10};
    vt[6] = '{3, 8'h80, 12'h300, 10};
    for (int i = 0; i < 4; i++) begin
      din[i] = 8'h00;
      we[i] = 1'b0;
      te[i] = 1'b1;
      co[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_tx%0d", i), 32'(tx[i]), 1);
      chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 0);
      chk($sformatf("rst_full%0d", i), 32'(full[i]), 0);
      chk($sformatf("rst_empty%0d", i), 32'(empty[i]), 1);
      chk($sformatf("rst_count%0d", i), 32'(cnt[i]), 0);
      chk($sformatf("rst_ovf%0d", i), 32'(ovf[i]), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int v = 0; v < 7; v++) send_frame(v);

    te[0] = 1'b0;
    we[0] = 1'b1;
    for (int i = 0; i < 64; i++) begin
      din[0] = 8'(i);
      @(negedge clk);
    end
    we[0] = 1'b0;
    chk("fill_full", 32'(full[0]), 1);
    chk("fill_count", 32'(cnt[0]), 64);
    chk("fill_ovf", 32'(ovf[0]), 0);
    din[0] = 8'hAA;
    we[0] = 1'b1;
    @(negedge clk);
    we[0] = 1'b0;
    chk("drop_ovf", 32'(ovf[0]), 1);
    chk("drop_count", 32'(cnt[0]), 64);
    co[0] = 1'b1;
    @(negedge clk);
    co[0] = 1'b0;
    chk("clr_ovf", 32'(ovf[0]), 0);
    we[0] = 1'b1;
    co[0] = 1'b1;
    @(negedge clk);
    we[0] = 1'b0;
    co[0] = 1'b0;
    chk("set_wins_ovf", 32'(ovf[0]), 1);
    co[0] = 1'b1;
    @(negedge clk);
    co[0] = 1'b0;
    chk("clr2_ovf", 32'(ovf[0]), 0);
    te[0] = 1'b1;
    we[0] = 1'b1;
    @(negedge clk);
    we[0] = 1'b0;
    chk("full_pop_count", 32'(cnt[0]), 63);
    chk("full_pop_ovf", 32'(ovf[0]), 1);
    chk("full_pop_busy", 32'(busy[0]), 1);
    do_reset();
    chk("after_rst_count", 32'(cnt[0]), 0);
    chk("after_rst_ovf", 32'(ovf[0]), 0);

    s = {10'h286, 10'h284, 10'h282};
    din[0] = 8'h41;
    we[0] = 1'b1;
    @(negedge clk);
    chk("b2b_count_c1", 32'(cnt[0]), 1);
    din[0] = 8'h42;
    @(negedge clk);
    chk("b2b_count_c2", 32'(cnt[0]), 1);
    din[0] = 8'h43;
    @(negedge clk);
    we[0] = 1'b0;
    chk("b2b_count_c3", 32'(cnt[0]), 2);
    for (int t = 3; t < 122; t++) begin
      chk($sformatf("b2b_tx_t%0d", t), 32'(tx[0]), 32'(s[(t - 2) / 4]));
      chk($sformatf("b2b_busy_t%0d", t), 32'(busy[0]), 1);
      @(negedge clk);
    end
    chk("b2b_busy_end", 32'(busy[0]), 0);
    chk("b2b_empty_end", 32'(empty[0]), 1);
    chk("b2b_tx_end", 32'(tx[0]), 1);

    din[0] = 8'h11;
    we[0] = 1'b1;
    @(negedge clk);
    din[0] = 8'h22;
    @(negedge clk);
    we[0] = 1'b0;
    @(negedge clk);
    te[0] = 1'b0;
    repeat (39) @(negedge clk);
    chk("hold_busy", 32'(busy[0]), 0);
    chk("hold_tx", 32'(tx[0]), 1);
    chk("hold_count", 32'(cnt[0]), 1);
    repeat (10) @(negedge clk);
    chk("hold2_busy", 32'(busy[0]), 0);
    chk("hold2_count", 32'(cnt[0]), 1);
    te[0] = 1'b1;
    @(negedge clk);
    chk("resume_busy", 32'(busy[0]), 1);
    chk("resume_tx", 32'(tx[0]), 0);
    chk("resume_count", 32'(cnt[0]), 0);
    do_reset();

    din[0] = 8'h00;
    we[0] = 1'b1;
    repeat (3) @(negedge clk);
    we[0] = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_tx", 32'(tx[0]), 0);
    chk("mid_count", 32'(cnt[0]), 2);
    chk("mid_busy", 32'(busy[0]), 1);
    rst = 1'b1;
    #1;
    chk("async_tx", 32'(tx[0]), 1);
    chk("async_busy", 32'(busy[0]), 0);
    chk("async_count", 32'(cnt[0]), 0);
    chk("async_empty", 32'(empty[0]), 1);
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      chk($sformatf("quiet_tx_t%0d", t), 32'(tx[0]), 1);
      chk($sformatf("quiet_busy_t%0d", t), 32'(busy[0]), 0);
    end
    chk("quiet_empty", 32'(empty[0]), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
